// File: rtl/scan_seq_pkg.sv
// Shared encodings for the scan-load sequencer: FSM states, host opcodes, result status
// and the readback byte alignment helper.
package scan_seq_pkg;

    localparam logic [2:0] StIdle      = 3'd0;
    localparam logic [2:0] StLoadWait  = 3'd1;
    localparam logic [2:0] StLoadShift = 3'd2;
    localparam logic [2:0] StRun       = 3'd3;
    localparam logic [2:0] StReadShift = 3'd4;
    localparam logic [2:0] StReadEmit  = 3'd5;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_READ = 2'b10;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_HALT    = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_ABORT   = 2'b11;

    // Captured bits enter at the MSB; a byte of n bits is shifted down so the first lands in bit 0.
    function automatic logic [7:0] align_byte(input logic [7:0] b, input logic [3:0] n);
        return b >> (4'd8 - n);
    endfunction

endpackage

// File: rtl/scan_load_sequencer_if.sv
// Host-side command, load-byte and readback-byte handshakes of the scan-load sequencer.
interface scan_load_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic       abort;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;
    logic [1:0] status;

    modport master (
        output cmd_valid, cmd_op, abort, in_valid, in_data, out_ready,
        input  cmd_ready, in_ready, out_valid, out_data, busy, status
    );

    modport slave (
        input  cmd_valid, cmd_op, abort, in_valid, in_data, out_ready,
        output cmd_ready, in_ready, out_valid, out_data, busy, status
    );
endinterface

// File: rtl/scan_byte_serdes.sv
// 8-bit shift register shared by load (parallel in, LSB-first serial out) and
// readback (serial in at the MSB, parallel out).
module scan_byte_serdes (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       shift,
    input  logic       shift_in,
    output logic       serial_out,
    output logic [7:0] par_out
);
    logic [7:0] sr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= load_data;
        end else if (shift) begin
            sr_q <= {shift_in, sr_q[7:1]};
        end
    end

    assign serial_out = sr_q[0];
    assign par_out    = sr_q;
endmodule

// File: rtl/scan_load_sequencer.sv
// Sequences the core through scan load, run and rotating (non-destructive) readback.
// Defining SCAN_SEQ_WATCHDOG_EN adds a RUN_LIMIT-cycle watchdog on the RUN phase.
module scan_load_sequencer
    import scan_seq_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 280,
    parameter int unsigned RUN_LIMIT = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    scan_load_sequencer_if.slave  host,
    output logic                  scan_enable,
    output logic                  scan_in,
    input  logic                  scan_out,
    output logic                  proc_en,
    input  logic                  halt
);
    localparam int unsigned CntW = $clog2(CHAIN_LEN + 1);

    logic [2:0]      state_q, state_d;
    logic [1:0]      status_q, status_d;
    logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
    logic [3:0]      byte_bits_q, byte_bits_d;
    logic            last_bit, all_done, last_in_byte;
    logic            ser_load, ser_shift_in, ser_bit;
    logic [7:0]      ser_byte;
    logic            run_expired;

    assign last_bit     = (bit_cnt_q == CntW'(CHAIN_LEN - 1));
    assign all_done     = (bit_cnt_q == CntW'(CHAIN_LEN));
    assign last_in_byte = (byte_bits_q == 4'd7);

`ifdef SCAN_SEQ_WATCHDOG_EN
    localparam int unsigned RunW = $clog2(RUN_LIMIT + 1);
    logic [RunW-1:0] run_cnt_q, run_cnt_d;

    assign run_expired = (run_cnt_q == RunW'(RUN_LIMIT - 1));

    // Exits RUN on the RUN_LIMIT-th proc_en cycle, so the counter never wraps.
    always_comb begin
        run_cnt_d = run_cnt_q;
        if (state_q == StIdle) begin
            run_cnt_d = '0;
        end else if (state_q == StRun) begin
            run_cnt_d = run_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) run_cnt_q <= '0;
        else     run_cnt_q <= run_cnt_d;
    end
`else
    logic unused_run_limit;
    assign unused_run_limit = ^{RUN_LIMIT, ST_TIMEOUT};
    assign run_expired      = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        status_d    = status_q;
        bit_cnt_d   = bit_cnt_q;
        byte_bits_d = byte_bits_q;
        case (state_q)
            StIdle: begin
                if (host.cmd_valid) begin
                    bit_cnt_d   = '0;
                    byte_bits_d = '0;
                    case (host.cmd_op)
                        OP_LOAD: state_d = StLoadWait;
                        OP_RUN:  state_d = StRun;
                        OP_READ: state_d = StReadShift;
                        default: status_d = ST_OK;
                    endcase
                end
            end
            StLoadWait: begin
                if (host.in_valid) begin
                    state_d     = StLoadShift;
                    byte_bits_d = '0;
                end
            end
            StLoadShift: begin
                bit_cnt_d   = bit_cnt_q + 1'b1;
                byte_bits_d = byte_bits_q + 1'b1;
                if (last_bit) begin
                    state_d  = StIdle;
                    status_d = ST_OK;
                end else if (last_in_byte) begin
                    state_d = StLoadWait;
                end
            end
            StRun: begin
                if (halt) begin
                    state_d  = StIdle;
                    status_d = ST_HALT;
                end else if (run_expired) begin
                    state_d  = StIdle;
                    status_d = ST_TIMEOUT;
                end
            end
            StReadShift: begin
                bit_cnt_d   = bit_cnt_q + 1'b1;
                byte_bits_d = byte_bits_q + 1'b1;
                if (last_bit || last_in_byte) state_d = StReadEmit;
            end
            StReadEmit: begin
                if (host.out_ready) begin
                    if (all_done) begin
                        state_d  = StIdle;
                        status_d = ST_OK;
                    end else begin
                        state_d     = StReadShift;
                        byte_bits_d = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // abort overrides halt, timeout and completion
        if (host.abort && (state_q != StIdle)) begin
            state_d  = StIdle;
            status_d = ST_ABORT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            status_q    <= ST_OK;
            bit_cnt_q   <= '0;
            byte_bits_q <= '0;
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_bits_q <= byte_bits_d;
        end
    end

    assign ser_load     = (state_q == StLoadWait) && host.in_valid;
    assign ser_shift_in = (state_q == StReadShift) && scan_out;

    scan_byte_serdes u_serdes (
        .clk        (clk),
        .rst        (rst),
        .load       (ser_load),
        .load_data  (host.in_data),
        .shift      (scan_enable),
        .shift_in   (ser_shift_in),
        .serial_out (ser_bit),
        .par_out    (ser_byte)
    );

    assign scan_enable = (state_q == StLoadShift) || (state_q == StReadShift);
    // Readback feeds the tail straight back into the head so the chain rotates intact.
    assign scan_in     = (state_q == StLoadShift) ? ser_bit :
                         (state_q == StReadShift) ? scan_out : 1'b0;
    assign proc_en     = (state_q == StRun);

    assign host.cmd_ready = (state_q == StIdle);
    assign host.busy      = (state_q != StIdle);
    assign host.in_ready  = (state_q == StLoadWait);
    assign host.out_valid = (state_q == StReadEmit);
    assign host.out_data  = (state_q == StReadEmit) ? align_byte(ser_byte, byte_bits_q) : 8'h00;
    assign host.status    = status_q;
endmodule

// File: tb/tb_scan_load_sequencer.sv
// Directed bench for scan_load_sequencer with a 20-bit behavioural scan chain.
module tb_scan_load_sequencer;
    import scan_seq_pkg::*;

    localparam int WInReady  = 0;
    localparam int WOutValid = 1;
    localparam int WIdle     = 2;

    typedef struct {
        logic [7:0]  b0, b1, b2;
        logic [19:0] stream;
        logic [23:0] rd;
        int          stall;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scan_enable, scan_in, scan_out, proc_en;
    logic        halt = 1'b0;
    logic [19:0] chain = '0;
    logic        se_hist [0:1023];
    int          n_cmp = 0, n_bad = 0;
    int          se_total = 0, pe_total = 0, busy_total = 0;
    vec_t        vecs [3];

    scan_load_sequencer_if bus ();

    scan_load_sequencer #(.CHAIN_LEN(20), .RUN_LIMIT(100)) dut (
        .clk         (clk),
        .rst         (rst),
        .host        (bus),
        .scan_enable (scan_enable),
        .scan_in     (scan_in),
        .scan_out    (scan_out),
        .proc_en     (proc_en),
        .halt        (halt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (scan_enable) chain <= {scan_in, chain[19:1]};
    assign scan_out = chain[0];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, want);
        end
    endtask

    // Every clock passes through here: invariants plus per-cycle activity logging.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("se_pe_exclusive", {31'd0, scan_enable & proc_en}, 32'd0);
        chk("cmd_ready_vs_busy", {31'd0, bus.cmd_ready}, {31'd0, !bus.busy});
        if (scan_enable) begin
            if (se_total < 1024) se_hist[se_total] = scan_in;
            se_total++;
        end
        if (proc_en) pe_total++;
        if (bus.busy) busy_total++;
    endtask

    function automatic logic cond(input int which);
        case (which)
            WInReady:  return bus.in_ready;
            WOutValid: return bus.out_valid;
            default:   return !bus.busy;
        endcase
    endfunction

    task automatic wait_for(input int which, input string nm);
        int n = 0;
        while (!cond(which) && n < 300) begin
            tick();
            n++;
        end
        if (!cond(which)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: condition still false after %0d cycles, expected true", nm, n);
        end
    endtask

    task automatic issue(input logic [1:0] op);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [23:0] bytes;
        bytes = {b2, b1, b0};
        issue(OP_LOAD);
        for (int k = 0; k < 3; k++) begin
            wait_for(WInReady, "load_in_ready");
            bus.in_valid = 1'b1;
            bus.in_data  = bytes[k*8 +: 8];
            tick();
            bus.in_valid = 1'b0;
        end
        wait_for(WIdle, "load_done");
    endtask

    task automatic do_read(input int stall, output logic [23:0] rd);
        int          se0;
        logic [7:0]  held;
        rd = '0;
        issue(OP_READ);
        for (int k = 0; k < 3; k++) begin
            wait_for(WOutValid, "read_out_valid");
            if (k == 0 && stall > 0) begin
                se0  = se_total;
                held = bus.out_data;
                for (int s = 0; s < stall; s++) tick();
                chk("stall_no_shift", se_total - se0, 0);
                chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
                chk("stall_data_held", {24'd0, bus.out_data}, {24'd0, held});
            end
            rd[k*8 +: 8] = bus.out_data;
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
        end
        wait_for(WIdle, "read_done");
    endtask

    initial begin
        int          s0, bz0, p0;
        logic [19:0] got;
        logic [23:0] rd;

        vecs[0] = '{b0: 8'hA5, b1: 8'h3C, b2: 8'h0F, stream: 20'hF3CA5, rd: 24'h0F3CA5, stall: 5};
        vecs[1] = '{b0: 8'h12, b1: 8'h34, b2: 8'hF6, stream: 20'h63412, rd: 24'h063412, stall: 0};
        vecs[2] = '{b0: 8'hFF, b1: 8'h00, b2: 8'hA0, stream: 20'h000FF, rd: 24'h0000FF, stall: 0};

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.abort     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;

        for (int i = 0; i < 3; i++) tick();
        chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_scan_en_proc_en", {30'd0, scan_enable, proc_en}, 32'd0);
        chk("rst_in_out_valid", {30'd0, bus.in_ready, bus.out_valid}, 32'd0);
        chk("rst_out_data_status", {22'd0, bus.out_data, bus.status}, 32'd0);
        chk("rst_scan_in", {31'd0, scan_in}, 32'd0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 3; v++) begin
            s0  = se_total;
            bz0 = busy_total;
            do_load(vecs[v].b0, vecs[v].b1, vecs[v].b2);
            for (int i = 0; i < 20; i++) got[i] = se_hist[s0 + i];
            chk("load_shift_cycles", se_total - s0, 20);
            chk("load_scan_in_stream", {12'd0, got}, {12'd0, vecs[v].stream});
            chk("load_busy_cycles", busy_total - bz0, 23);
            chk("load_status", {30'd0, bus.status}, {30'd0, ST_OK});
            chk("chain_after_load", {12'd0, chain}, {12'd0, vecs[v].stream});

            s0  = se_total;
            bz0 = busy_total;
            do_read(vecs[v].stall, rd);
            chk("read_bytes", {8'd0, rd}, {8'd0, vecs[v].rd});
            chk("read_shift_cycles", se_total - s0, 20);
            chk("read_busy_cycles", busy_total - bz0, 23 + vecs[v].stall);
            chk("chain_after_read", {12'd0, chain}, {12'd0, vecs[v].stream});
            chk("read_status", {30'd0, bus.status}, {30'd0, ST_OK});
        end

        // RUN with halt raised 10 cycles after proc_en rises
        p0 = pe_total;
        issue(OP_RUN);
        chk("run_proc_en_rises", {31'd0, proc_en}, 32'd1);
        for (int i = 0; i < 10; i++) tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("run_halt_pe_cycles", pe_total - p0, 11);
        chk("run_halt_status", {30'd0, bus.status}, {30'd0, ST_HALT});
        chk("run_halt_idle", {31'd0, bus.busy}, 32'd0);

        // abort in the 3rd LOAD_SHIFT cycle
        issue(OP_LOAD);
        wait_for(WInReady, "abort_in_ready");
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("abort_pre_shifting", {31'd0, scan_enable}, 32'd1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_scan_en_low", {31'd0, scan_enable}, 32'd0);
        chk("abort_busy_low", {31'd0, bus.busy}, 32'd0);
        chk("abort_status", {30'd0, bus.status}, {30'd0, ST_ABORT});
        for (int i = 0; i < 3; i++) tick();
        chk("abort_in_ready_stays_low", {31'd0, bus.in_ready}, 32'd0);

        // abort in IDLE is ignored
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("idle_abort_status_held", {30'd0, bus.status}, {30'd0, ST_ABORT});
        chk("idle_abort_busy", {31'd0, bus.busy}, 32'd0);

        // halt already high on entry: single proc_en pulse
        halt = 1'b1;
        p0   = pe_total;
        issue(OP_RUN);
        tick();
        halt = 1'b0;
        chk("halt_on_entry_pe_cycles", pe_total - p0, 1);
        chk("halt_on_entry_status", {30'd0, bus.status}, {30'd0, ST_HALT});

        // abort and halt in the same cycle: abort wins
        issue(OP_RUN);
        tick();
        halt      = 1'b1;
        bus.abort = 1'b1;
        tick();
        halt      = 1'b0;
        bus.abort = 1'b0;
        chk("abort_beats_halt_status", {30'd0, bus.status}, {30'd0, ST_ABORT});
        chk("abort_beats_halt_pe", {31'd0, proc_en}, 32'd0);

        // reserved opcode is a no-op that reports ok
        issue(2'b11);
        chk("reserved_busy", {31'd0, bus.busy}, 32'd0);
        chk("reserved_status", {30'd0, bus.status}, {30'd0, ST_OK});

        // no halt at all
        p0 = pe_total;
        issue(OP_RUN);
`ifdef SCAN_SEQ_WATCHDOG_EN
        wait_for(WIdle, "watchdog_expiry");
        chk("watchdog_pe_cycles", pe_total - p0, 100);
        chk("watchdog_status", {30'd0, bus.status}, {30'd0, ST_TIMEOUT});
`else
        for (int i = 0; i < 1000; i++) tick();
        chk("no_watchdog_pe_at_1000", {31'd0, proc_en}, 32'd1);
        chk("no_watchdog_pe_cycles", pe_total - p0, 1001);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("no_watchdog_abort_status", {30'd0, bus.status}, {30'd0, ST_ABORT});
`endif

        // reset in the middle of a load
        issue(OP_LOAD);
        wait_for(WInReady, "midrst_in_ready");
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_scan_en", {31'd0, scan_enable}, 32'd0);
        chk("midrst_status", {30'd0, bus.status}, {30'd0, ST_OK});
        tick();
        chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/scan_load_sequencer.md
Name: scan_load_sequencer

Overview:
- Host-side controller that sequences the accumulator microcontroller through its three phases: program load over the scan chain, execution, and non-destructive state readback.
- Sits between a byte-wide host interface (valid/ready) and the core's scan_enable/scan_in/scan_out/proc_en/halt pins.
- Sole owner of scan_enable and proc_en. The two are never asserted in the same cycle.

Parameters:
- CHAIN_LEN, 280, total scan-chain length in bits (control unit + PC + IR + ACC + 32x8 memory)
- RUN_LIMIT, 65535, maximum proc_en cycles before watchdog abort (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  00 LOAD, 01 RUN, 10 READ, 11 reserved (accepted, no-op, status 00)
- abort  in  1  single-cycle request to stop any operation
- in_valid  in  1  load byte valid
- in_ready  out  1  load byte ready
- in_data  in  8  load byte, shifted LSB first
- out_valid  out  1  readback byte valid
- out_ready  in  1  readback byte ready
- out_data  out  8  readback byte; first captured bit in bit 0
- scan_enable  out  1  to core
- scan_in  out  1  to core chain head
- scan_out  in  1  from core chain tail
- proc_en  out  1  to core
- halt  in  1  from core
- busy  out  1  state != IDLE
- status  out  2  last result: 00 ok, 01 halted, 10 timeout, 11 aborted

Behaviour:
- Clocking and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: state IDLE; cmd_ready=1; all other outputs 0; bit counter 0.
- Reset mid-operation: same as reset. Chain contents are then undefined.
- States: IDLE, LOAD_WAIT, LOAD_SHIFT, RUN, READ_SHIFT, READ_EMIT.
- IDLE: cmd_valid & cmd_ready transfers cmd_op.
  - LOAD -> LOAD_WAIT; RUN -> RUN; READ -> READ_SHIFT.
  - Counters clear on acceptance.
- LOAD_WAIT: in_ready=1. On in_valid the byte latches into the serialiser -> LOAD_SHIFT.
- LOAD_SHIFT:
  - scan_enable=1; scan_in = serialiser bit 0; one bit per cycle.
  - Bit counter increments per shifted bit.
  - Leave after 8 bits, or when counter reaches CHAIN_LEN.
  - If counter == CHAIN_LEN -> IDLE, status 00; otherwise -> LOAD_WAIT.
  - Surplus bits of a final partial byte are discarded. ceil(CHAIN_LEN/8) bytes are consumed.
- Throughput: with back-to-back in_valid, each byte costs 1 accept cycle + 8 shift cycles.
- RUN:
  - proc_en=1 starting the cycle after acceptance.
  - When halt is sampled high: proc_en drops the next cycle -> IDLE, status 01.
  - If halt is already high on entry, proc_en pulses for exactly 1 cycle.
- READ_SHIFT:
  - scan_enable=1; scan_out is captured into the deserialiser MSB-shift and simultaneously driven on scan_in, so the chain rotates.
  - After CHAIN_LEN shifts the chain content is unchanged.
  - After 8 captured bits, or the final bit, -> READ_EMIT.
- READ_EMIT:
  - scan_enable=0; out_valid=1 holding the byte.
  - A final partial byte is right-aligned: first captured bit in bit 0, upper bits zero.
  - On out_ready: if all CHAIN_LEN bits are done -> IDLE, status 00; else -> READ_SHIFT.
  - No shifting occurs while a byte is pending.
- abort: in any non-IDLE state, the next cycle drops scan_enable/proc_en/in_ready/out_valid -> IDLE, status 11.
  - In IDLE, abort is ignored and status is held.
  - abort has priority over a simultaneous halt or completion.
- status updates only on return to IDLE. It persists until the next command completes.
- Bit counter width is $clog2(CHAIN_LEN+1) and it never wraps.

Optional Feature:
- Macro SCAN_SEQ_WATCHDOG_EN.
- Defined: a RUN cycle counter ($clog2(RUN_LIMIT+1) bits) counts proc_en cycles.
  - On reaching RUN_LIMIT without halt: proc_en drops -> IDLE, status 10.
  - halt on the same cycle as the limit wins (status 01).
- Undefined: no counter; RUN waits indefinitely for halt or abort; status 10 is never produced.

Decomposition:
- Package scan_seq_pkg holds:
  - state enum
  - cmd_op encodings (OP_LOAD/OP_RUN/OP_READ)
  - status encodings (ST_OK/ST_HALT/ST_TIMEOUT/ST_ABORT)
- One sub-module, scan_byte_serdes: 8-bit shift register with parallel load, serial out (LSB first), serial-in capture, and parallel out. It is shared by the load and read paths.

Test Plan:
- CHAIN_LEN=20, LOAD with bytes 0xA5, 0x3C, 0x0F -> exactly 20 scan_enable cycles; scan_in sequence 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1; status 00; third byte's high nibble dropped.
- LOAD then READ against a 20-bit behavioural chain model -> out bytes 0xA5, 0x3C, 0x0F; chain model unchanged after; out_ready held low 5 cycles stalls scan_enable for those cycles.
- RUN, halt asserted 10 cycles after proc_en rises -> proc_en high 11 cycles, status 01; RUN with halt already high -> 1-cycle proc_en pulse.
- abort in the 3rd LOAD_SHIFT cycle -> scan_enable low next cycle, busy low, status 11; in_ready stays 0 until a new LOAD.
- With SCAN_SEQ_WATCHDOG_EN and RUN_LIMIT=100, halt never asserted -> proc_en high exactly 100 cycles, status 10; without the macro, proc_en is still high at cycle 1000.
- Invariant check throughout: scan_enable & proc_en never both 1; cmd_ready==!busy.
